// File: rtl/vga_pkg.sv
// Shared VGA/sprite types and defaults for the sprite overlay blocks.
package vga_pkg;

  localparam int          SPR_W_DEF   = 48;
  localparam int          SPR_H_DEF   = 64;
  localparam logic [11:0] KEY_RGB_DEF = 12'hFAC;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [1:0]  level;
    logic        en;
    logic        mirror;
  } spr_attr_t;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_sig_t;

endpackage

// File: rtl/vga_if.sv
// VGA timing/pixel bundle with producer (out) and consumer (in) views.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/sprite_hit_calc.sv
// One sprite channel: visibility plus window test, and the local column/row
// of the current pixel inside the sprite (column flipped when mirrored).
module sprite_hit_calc
  import vga_pkg::*;
#(
  parameter int SPR_W = SPR_W_DEF,
  parameter int SPR_H = SPR_H_DEF,
  localparam int COL_W = $clog2(SPR_W),
  localparam int ROW_W = $clog2(SPR_H)
) (
  input  spr_attr_t        attr,
  input  logic [1:0]       level_home,
  input  logic [10:0]      hcount,
  input  logic [10:0]      vcount,
  output logic             hit,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row
);

  logic [12:0] h_ext, v_ext, x_ext, y_ext, x_end, y_end, dx, dy;
  logic        in_x, in_y, visible;

  // 13-bit sums so sprites hanging off the right/bottom edge never wrap to 0
  always_comb begin
    h_ext   = {2'b00, hcount};
    v_ext   = {2'b00, vcount};
    x_ext   = {1'b0, attr.x};
    y_ext   = {1'b0, attr.y};
    x_end   = x_ext + 13'(SPR_W);
    y_end   = y_ext + 13'(SPR_H);
    in_x    = (h_ext >= x_ext) && (h_ext < x_end);
    in_y    = (v_ext >= y_ext) && (v_ext < y_end);
    visible = attr.en && (attr.level == level_home);
    hit     = visible && in_x && in_y;
    dx      = h_ext - x_ext;
    dy      = v_ext - y_ext;
    col     = attr.mirror ? (COL_W'(SPR_W - 1) - COL_W'(dx)) : COL_W'(dx);
    row     = ROW_W'(dy);
  end

endmodule

// File: rtl/draw_sprites_multi.sv
// Overlays up to N_SPR sprites from one shared ROM onto a VGA stream; the
// lowest-index hit wins and the vga fields are delayed to match ROM latency.
module draw_sprites_multi
  import vga_pkg::*;
#(
  parameter int          N_SPR   = 2,
  parameter int          SPR_W   = SPR_W_DEF,
  parameter int          SPR_H   = SPR_H_DEF,
  parameter int          ROM_LAT = 1,
  parameter logic [11:0] KEY_RGB = KEY_RGB_DEF,
  localparam int         ADDR_W  = $clog2(SPR_W * SPR_H)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_SPR-1:0][11:0] x_value,
  input  logic [N_SPR-1:0][11:0] y_value,
  input  logic [N_SPR-1:0][1:0]  spr_level,
  input  logic [1:0]             level_home,
  input  logic [N_SPR-1:0]       spr_en,
  input  logic [N_SPR-1:0]       spr_mirror,
  output logic [ADDR_W-1:0]      pixel_addr,
  input  logic [11:0]            rgb_pixel,
  output logic                   overlap,
  vga_if.in                      vga_in,
  vga_if.out                     vga_out
);

  localparam int L     = ROM_LAT + 2;
  localparam int COL_W = $clog2(SPR_W);
  localparam int ROW_W = $clog2(SPR_H);

  logic                         vblnk_prev_q, vblnk_prev_d, vblnk_rise;
  spr_attr_t [N_SPR-1:0]        shadow_q, shadow_d;
  logic [N_SPR-1:0]             hit;
  logic [N_SPR-1:0][COL_W-1:0]  col;
  logic [N_SPR-1:0][ROW_W-1:0]  row;
  logic                         hit_any, multi_hit, set_now;
  logic [COL_W-1:0]             win_col;
  logic [ROW_W-1:0]             win_row;
  logic                         hit0_q, hit0_d;
  logic [ADDR_W-1:0]            addr_q, addr_d;
  logic [ROM_LAT-1:0]           hit_pipe_q, hit_pipe_d;
  vga_sig_t [L-2:0]             vga_pipe_q, vga_pipe_d;
  vga_sig_t                     cur_vga, out_q, out_d;
  logic                         sticky_q, sticky_d, overlap_q, overlap_d;

  assign vblnk_rise = vga_in.vblnk & ~vblnk_prev_q;

  // Attributes only move at the start of vertical blanking
  always_comb begin
    vblnk_prev_d = vga_in.vblnk;
    shadow_d     = shadow_q;
    if (vblnk_rise) begin
      for (int i = 0; i < N_SPR; i++) begin
        shadow_d[i].x      = x_value[i];
        shadow_d[i].y      = y_value[i];
        shadow_d[i].level  = spr_level[i];
        shadow_d[i].en     = spr_en[i];
        shadow_d[i].mirror = spr_mirror[i];
      end
    end
  end

  for (genvar g = 0; g < N_SPR; g++) begin : g_hit
    sprite_hit_calc #(
      .SPR_W(SPR_W),
      .SPR_H(SPR_H)
    ) u_hit (
      .attr      (shadow_q[g]),
      .level_home(level_home),
      .hcount    (vga_in.hcount),
      .vcount    (vga_in.vcount),
      .hit       (hit[g]),
      .col       (col[g]),
      .row       (row[g])
    );
  end

  always_comb begin
    hit_any   = 1'b0;
    multi_hit = 1'b0;
    win_col   = '0;
    win_row   = '0;
    for (int i = 0; i < N_SPR; i++) begin
      multi_hit = multi_hit | (hit_any & hit[i]);
      if (hit[i] && !hit_any) begin
        win_col = col[i];
        win_row = row[i];
      end
      hit_any = hit_any | hit[i];
    end
    set_now = multi_hit & ~vga_in.hblnk & ~vga_in.vblnk;
  end

  always_comb begin
    hit0_d = hit_any;
    addr_d = '0;
    if (hit_any) addr_d = ADDR_W'(int'(win_row) * SPR_W + int'(win_col));

    cur_vga.hcount = vga_in.hcount;
    cur_vga.vcount = vga_in.vcount;
    cur_vga.hsync  = vga_in.hsync;
    cur_vga.vsync  = vga_in.vsync;
    cur_vga.hblnk  = vga_in.hblnk;
    cur_vga.vblnk  = vga_in.vblnk;
    cur_vga.rgb    = vga_in.rgb;

    hit_pipe_d[0] = hit0_q;
    for (int i = 1; i < ROM_LAT; i++) hit_pipe_d[i] = hit_pipe_q[i-1];
    vga_pipe_d[0] = cur_vga;
    for (int i = 1; i < L - 1; i++) vga_pipe_d[i] = vga_pipe_q[i-1];

    out_d = vga_pipe_q[L-2];
    if (hit_pipe_q[ROM_LAT-1] && (rgb_pixel != KEY_RGB)) out_d.rgb = rgb_pixel;
  end

  // A set landing in the vblnk-rise cycle belongs to the frame that follows
  always_comb begin
    sticky_d  = sticky_q | set_now;
    overlap_d = overlap_q;
    if (vblnk_rise) begin
      overlap_d = sticky_q;
      sticky_d  = set_now;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_prev_q <= 1'b0;
      shadow_q     <= '0;
      hit0_q       <= 1'b0;
      addr_q       <= '0;
      hit_pipe_q   <= '0;
      vga_pipe_q   <= '0;
      out_q        <= '0;
      sticky_q     <= 1'b0;
      overlap_q    <= 1'b0;
    end else begin
      vblnk_prev_q <= vblnk_prev_d;
      shadow_q     <= shadow_d;
      hit0_q       <= hit0_d;
      addr_q       <= addr_d;
      hit_pipe_q   <= hit_pipe_d;
      vga_pipe_q   <= vga_pipe_d;
      out_q        <= out_d;
      sticky_q     <= sticky_d;
      overlap_q    <= overlap_d;
    end
  end

  assign pixel_addr     = addr_q;
  assign overlap        = overlap_q;
  assign vga_out.hcount = out_q.hcount;
  assign vga_out.vcount = out_q.vcount;
  assign vga_out.hsync  = out_q.hsync;
  assign vga_out.vsync  = out_q.vsync;
  assign vga_out.hblnk  = out_q.hblnk;
  assign vga_out.vblnk  = out_q.vblnk;
  assign vga_out.rgb    = out_q.rgb;

endmodule

// File: tb/tb_draw_sprites_multi.sv
// Randomized bench for draw_sprites_multi against a frame-level sprite model
// with a synchronous ROM driven from the DUT address.
module tb_draw_sprites_multi;
  import vga_pkg::*;

  localparam int          N_SPR   = 2;
  localparam int          SPR_W   = 48;
  localparam int          SPR_H   = 64;
  localparam int          ROM_LAT = 1;
  localparam int          L       = ROM_LAT + 2;
  localparam int          ADDR_W  = $clog2(SPR_W * SPR_H);
  localparam logic [11:0] KEY     = 12'hFAC;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic [N_SPR-1:0][11:0] x_value = '0;
  logic [N_SPR-1:0][11:0] y_value = '0;
  logic [N_SPR-1:0][1:0]  spr_level = '0;
  logic [1:0]             level_home = '0;
  logic [N_SPR-1:0]       spr_en = '0;
  logic [N_SPR-1:0]       spr_mirror = '0;
  logic [ADDR_W-1:0]      pixel_addr;
  logic [11:0]            rgb_pixel = '0;
  logic                   overlap;

  vga_if vga_in_if ();
  vga_if vga_out_if ();

  draw_sprites_multi #(
    .N_SPR(N_SPR), .SPR_W(SPR_W), .SPR_H(SPR_H), .ROM_LAT(ROM_LAT), .KEY_RGB(KEY)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .x_value(x_value), .y_value(y_value), .spr_level(spr_level),
    .level_home(level_home), .spr_en(spr_en), .spr_mirror(spr_mirror),
    .pixel_addr(pixel_addr), .rgb_pixel(rgb_pixel), .overlap(overlap),
    .vga_in(vga_in_if), .vga_out(vga_out_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  int   sh_x [N_SPR];
  int   sh_y [N_SPR];
  int   sh_lvl [N_SPR];
  bit   sh_en [N_SPR];
  bit   sh_mir [N_SPR];
  bit   prev_vb;
  bit   frame_multi;
  bit   exp_overlap;
  int   exp_addr;
  logic [37:0]       exp_out_q [$];
  logic [ADDR_W-1:0] addr_hist [$];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [11:0] rom(input int a);
    logic [11:0] v;
    if (a % 5 == 3) return KEY;
    v = 12'((a * 53 + 17) ^ (a >> 3));
    if (v == KEY) v = 12'h123;
    return v;
  endfunction

  function automatic logic [37:0] vgaOutBits();
    return {vga_out_if.hcount, vga_out_if.vcount, vga_out_if.hsync, vga_out_if.vsync,
            vga_out_if.hblnk, vga_out_if.vblnk, vga_out_if.rgb};
  endfunction

  task automatic modelReset();
    for (int i = 0; i < N_SPR; i++) begin
      sh_x[i] = 0; sh_y[i] = 0; sh_lvl[i] = 0; sh_en[i] = 0; sh_mir[i] = 0;
    end
    prev_vb = 0; frame_multi = 0; exp_overlap = 0; exp_addr = 0;
    exp_out_q.delete();
    addr_hist.delete();
    for (int i = 0; i < L; i++) exp_out_q.push_back('0);
  endtask

  // Called at a falling edge: check what the last rising edge produced, then
  // drive this cycle's pixel and advance the reference model by one pixel.
  task automatic applyStimulus(input int h, input int v, input bit hb, input bit vb,
                               input bit hs, input bit vs, input logic [11:0] rgb_in);
    int hits, win, addr;
    logic [11:0] pix, rgb_o;
    checkOutput("vga_out", 64'(vgaOutBits()), 64'(exp_out_q.pop_front()));
    checkOutput("pixel_addr", 64'(pixel_addr), 64'(exp_addr));
    checkOutput("overlap", 64'(overlap), 64'(exp_overlap));

    addr_hist.push_back(pixel_addr);
    if (addr_hist.size() > ROM_LAT + 1) void'(addr_hist.pop_front());
    rgb_pixel = (addr_hist.size() > ROM_LAT) ? rom(int'(addr_hist[0])) : 12'h000;

    vga_in_if.hcount = 11'(h);
    vga_in_if.vcount = 11'(v);
    vga_in_if.hblnk  = hb;
    vga_in_if.vblnk  = vb;
    vga_in_if.hsync  = hs;
    vga_in_if.vsync  = vs;
    vga_in_if.rgb    = rgb_in;

    hits = 0; win = -1; addr = 0;
    for (int i = 0; i < N_SPR; i++) begin
      if (sh_en[i] && sh_lvl[i] == int'(level_home) &&
          h >= sh_x[i] && h < sh_x[i] + SPR_W && v >= sh_y[i] && v < sh_y[i] + SPR_H) begin
        hits++;
        if (win < 0) win = i;
      end
    end
    if (win >= 0)
      addr = (v - sh_y[win]) * SPR_W + (sh_mir[win] ? SPR_W - 1 - (h - sh_x[win]) : h - sh_x[win]);
    pix   = rom(addr);
    rgb_o = (win >= 0 && pix != KEY) ? pix : rgb_in;
    exp_out_q.push_back({11'(h), 11'(v), hs, vs, hb, vb, rgb_o});
    exp_addr = addr;

    if (hits >= 2 && !hb && !vb) frame_multi = 1;
    if (vb && !prev_vb) begin
      exp_overlap = frame_multi;
      frame_multi = 0;
      for (int i = 0; i < N_SPR; i++) begin
        sh_x[i] = int'(x_value[i]); sh_y[i] = int'(y_value[i]);
        sh_lvl[i] = int'(spr_level[i]); sh_en[i] = spr_en[i]; sh_mir[i] = spr_mirror[i];
      end
    end
    prev_vb = vb;
  endtask

  task automatic pix(input int h, input int v, input bit hb, input bit vb);
    applyStimulus(h, v, hb, vb, 1'($urandom), 1'($urandom), 12'($urandom));
    @(negedge clk);
  endtask

  task automatic blankPulse();
    pix(1100, 800, 1, 1);
    pix(1100, 801, 1, 1);
    pix(1100, 802, 1, 0);
  endtask

  task automatic randomAttrs();
    for (int i = 0; i < N_SPR; i++) begin
      x_value[i]    = 12'($urandom_range(0, 1100));
      y_value[i]    = 12'($urandom_range(0, 800));
      spr_level[i]  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : level_home;
      spr_en[i]     = ($urandom_range(0, 5) != 0);
      spr_mirror[i] = 1'($urandom);
    end
    if ($urandom_range(0, 2) == 0) begin
      x_value[1] = 12'(int'(x_value[0]) + int'($urandom_range(0, 40)));
      y_value[1] = 12'(int'(y_value[0]) + int'($urandom_range(0, 40)));
    end
  endtask

  task automatic midReset();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_vga_out", 64'(vgaOutBits()), 64'(0));
    checkOutput("rst_pixel_addr", 64'(pixel_addr), 64'(0));
    checkOutput("rst_overlap", 64'(overlap), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
  endtask

  initial begin
    vga_in_if.hcount = '0; vga_in_if.vcount = '0; vga_in_if.hsync = 1'b0;
    vga_in_if.vsync = 1'b0; vga_in_if.hblnk = 1'b0; vga_in_if.vblnk = 1'b0;
    vga_in_if.rgb = '0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("init_vga_out", 64'(vgaOutBits()), 64'(0));
    checkOutput("init_pixel_addr", 64'(pixel_addr), 64'(0));
    checkOutput("init_overlap", 64'(overlap), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();

    // Sprite 0 at (100,200); nothing drawn before the first latch
    level_home = 2'd1; spr_level = {2'd1, 2'd1}; spr_en = 2'b01; spr_mirror = 2'b00;
    x_value[0] = 12'd100; y_value[0] = 12'd200; x_value[1] = 12'd900; y_value[1] = 12'd600;
    pix(101, 200, 0, 0);
    checkOutput("pre_latch_addr", 64'(pixel_addr), 64'(0));
    blankPulse();
    pix(101, 200, 0, 0);
    checkOutput("plain_h101", 64'(pixel_addr), 64'(1));
    pix(100, 201, 0, 0);
    checkOutput("plain_h100_v201", 64'(pixel_addr), 64'(48));

    spr_mirror = 2'b01;
    blankPulse();
    pix(100, 201, 0, 0);
    checkOutput("mirror_h100", 64'(pixel_addr), 64'(95));
    pix(147, 201, 0, 0);
    checkOutput("mirror_h147", 64'(pixel_addr), 64'(48));
    pix(148, 201, 0, 0);
    checkOutput("mirror_h148", 64'(pixel_addr), 64'(0));

    x_value[0] = 12'd400;
    pix(100, 202, 0, 0);
    checkOutput("shadow_hold", 64'(pixel_addr), 64'(143));
    blankPulse();
    pix(100, 202, 0, 0);
    checkOutput("shadow_old_gone", 64'(pixel_addr), 64'(0));
    pix(400, 202, 0, 0);
    checkOutput("shadow_new", 64'(pixel_addr), 64'(143));

    // Two sprites stacked at (300,300)
    spr_mirror = 2'b00; spr_en = 2'b11;
    x_value[0] = 12'd300; y_value[0] = 12'd300; x_value[1] = 12'd300; y_value[1] = 12'd300;
    blankPulse();
    checkOutput("overlap_before", 64'(overlap), 64'(0));
    pix(310, 310, 0, 0);
    pix(330, 340, 0, 0);
    x_value[1] = 12'd600;
    blankPulse();
    checkOutput("overlap_set", 64'(overlap), 64'(1));
    level_home = 2'd2;
    pix(310, 310, 0, 0);
    checkOutput("level_mismatch", 64'(pixel_addr), 64'(0));
    level_home = 2'd1;
    pix(310, 310, 0, 0);
    pix(600, 310, 0, 0);
    blankPulse();
    checkOutput("overlap_clear", 64'(overlap), 64'(0));

    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 3) == 0) level_home = 2'($urandom);
      randomAttrs();
      blankPulse();
      for (int c = 0; c < 120; c++) begin
        int s, h, v;
        if (c == 60) randomAttrs();
        if (f == 20 && c == 40) midReset();
        s = int'($urandom_range(0, N_SPR - 1));
        h = sh_x[s] + int'($urandom_range(0, SPR_W + 15)) - 8;
        v = sh_y[s] + int'($urandom_range(0, SPR_H + 15)) - 8;
        if ($urandom_range(0, 7) == 0) begin
          h = int'($urandom_range(0, 1343));
          v = int'($urandom_range(0, 805));
        end
        if (h < 0) h = 0;
        if (v < 0) v = 0;
        pix(h, v, ($urandom_range(0, 9) == 0), 0);
      end
    end
    blankPulse();
    pix(0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/draw_sprites_multi.md
DRAW_SPRITES_MULTI -- requirements
Module: draw_sprites_multi

Interface
REQ-001 Parameter N_SPR, default 2: number of remote sprite channels (1..4).
REQ-002 Parameter SPR_W, default 48: sprite width in pixels.
REQ-003 Parameter SPR_H, default 64: sprite height in pixels.
REQ-004 Parameter ROM_LAT, default 1: sprite-ROM read latency in clk cycles (1..3).
REQ-005 Parameter KEY_RGB, default 12'hFAC: transparent colour key.
REQ-006 clk  in  1  pixel clock; all state on its rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 x_value  in  N_SPR x 12  per-sprite left edge (screen pixels).
REQ-009 y_value  in  N_SPR x 12  per-sprite top edge.
REQ-010 spr_level  in  N_SPR x 2  level each sprite is on.
REQ-011 level_home  in  2  level currently displayed.
REQ-012 spr_en  in  N_SPR  per-sprite enable.
REQ-013 spr_mirror  in  N_SPR  per-sprite horizontal flip.
REQ-014 pixel_addr  out  ADDR_W = clog2(SPR_W*SPR_H)  shared sprite-ROM address.
REQ-015 rgb_pixel  in  12  ROM data, valid ROM_LAT cycles after pixel_addr.
REQ-016 overlap  out  1  previous frame had two visible sprites covering one pixel.
REQ-017 vga_in  vga_if.in; vga_out  vga_if.out (hcount/vcount 11b, hsync, vsync, hblnk, vblnk, rgb 12b).

Function
REQ-018 Sprite attributes SHALL be copied to shadow registers only in the cycle where vga_in.vblnk rises (0->1), so no frame shows a mid-frame position change.
REQ-019 Sprite i SHALL be visible when its shadow enable is 1 and shadow level equals level_home (live value).
REQ-020 Hit i SHALL be x_i <= hcount < x_i+SPR_W and y_i <= vcount < y_i+SPR_H, sums computed 13-bit without wrap.
REQ-021 When several sprites hit, the lowest index SHALL win.
REQ-022 Stage 0 SHALL register hit flag, winning index and pixel_addr = (vcount-y)*SPR_W + col, col = hcount-x, or SPR_W-1-(hcount-x) when mirrored.
REQ-023 With no hit, pixel_addr SHALL be 0.
REQ-024 All vga signals SHALL be delayed by L = ROM_LAT+2 cycles, identical for every field.
REQ-025 Output rgb SHALL be rgb_pixel if the delayed hit flag is 1 and rgb_pixel != KEY_RGB, else the delayed vga_in.rgb.
REQ-026 Sticky internal flag SHALL set when two or more visible sprites hit the same (hcount,vcount) while hblnk=0 and vblnk=0, geometry-only (transparency ignored).
REQ-027 At each vblnk rising edge, overlap SHALL take the sticky flag value and the sticky flag SHALL clear; simultaneous set in that cycle SHALL count for the next frame.
REQ-028 Sprites partly beyond 1023/767 SHALL draw clipped with no wrap to column/row 0.

Reset
REQ-029 While rst_n=0: all vga_out fields, pixel_addr, overlap, pipeline and shadow registers SHALL be 0.
REQ-030 After reset release nothing SHALL be drawn until the first vblnk rising edge latches shadows; reset mid-frame SHALL discard that frame's overlap.

Structure
REQ-031 KEY_RGB default, SPR_W/SPR_H defaults and the sprite attribute struct (x, y, level, en, mirror) SHALL live in vga_pkg.
REQ-032 One sub-module, sprite_hit_calc (one channel: hit flag plus local column/row), SHALL be instantiated N_SPR times.

Verification
REQ-033 N_SPR=2, sprite0 at (100,200), level match -> first non-key pixel at hcount 100, vcount 200 appears on vga_out L cycles later; pixel_addr=0 there.
REQ-034 spr_mirror0=1 at (100,200) -> pixel_addr at hcount 100 equals 47; at hcount 147 equals 0; hcount 148 no hit.
REQ-035 Sprites 0 and 1 both at (300,300) -> sprite0 pixels drawn; overlap=1 after the next vblnk rise, 0 a frame after separation.
REQ-036 x_value0 changed from 100 to 400 mid-frame -> sprite stays at 100 until the next vblnk rise, then at 400.
REQ-037 rgb_pixel=12'hFAC inside window -> background rgb passes; level_home != spr_level -> no draw.
REQ-038 rst_n pulsed low mid-line -> outputs 0 asynchronously; no sprite drawn until after the next vblnk rise.
